add_subt_pipe: RTL and testbench

Pipelined, parametrised significand adder/subtractor for the FPU add/subtract datapath. It sits between the alignment shifter and the LZA/normaliser. The carry chain is split into two registered segments so wide significands close timing. A valid/ready handshake with full backpressure is added, and a compile-time option returns the magnitude of a negative difference together with a sign-flip flag.

---
 rtl/add_subt_pkg.sv | 6 +
 rtl/add_seg.sv | 16 +
 rtl/add_subt_pipe.sv | 175 +++++++++++++++++
 tb/tb_add_subt_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/add_subt_pkg.sv
// Shared constants for the pipelined significand adder/subtractor.
package add_subt_pkg;
  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_SUB  = 1'b1;
  localparam int   SWR_DEF = 26;
endpackage

// File: rtl/add_seg.sv
// Parametrised ripple segment: {cout, sum} = a + b + cin.
module add_seg #(
  parameter int W = 13
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] w_full;

  assign w_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum    = w_full[W-1:0];
  assign cout   = w_full[W];
endmodule

// File: rtl/add_subt_pipe.sv
// Two-segment pipelined significand add/sub with valid/ready backpressure.
// ADD_SUBT_ABS_EN adds a third stage returning |A-B| and a sign-flip flag.
module add_subt_pipe
  import add_subt_pkg::*;
#(
  parameter int SWR = SWR_DEF,
  parameter int LSW = SWR / 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic           add_sub_op_i,
  input  logic [SWR-1:0] data_a_i,
  input  logic [SWR-1:0] data_b_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [SWR-1:0] result_o,
  output logic           carry_o,
  output logic [SWR-1:0] p_o,
  output logic           zero_o,
  output logic           sign_flip_o
);
  localparam int HSW = SWR - LSW;

  logic           r_v1, r_v2;
  logic           w_en1, w_en2, w_acc;

  // A stage may load when empty or when its content moves on this cycle.
`ifdef ADD_SUBT_ABS_EN
  logic r_v3;
  logic w_en3;
  assign w_en3 = !r_v3 | ready_i;
  assign w_en2 = !r_v2 | w_en3;
`else
  assign w_en2 = !r_v2 | ready_i;
`endif
  assign w_en1   = !r_v1 | w_en2;
  assign ready_o = w_en1;
  assign w_acc   = valid_i & w_en1;

  // ---------------- S1: low segment ----------------
  logic [SWR-1:0] w_b_eff;
  logic           w_cin;
  logic [LSW-1:0] w_sum_lo;
  logic           w_c_lo;

  assign w_cin   = (add_sub_op_i == OP_SUB);
  assign w_b_eff = w_cin ? ~data_b_i : data_b_i;

  add_seg #(.W(LSW)) u_seg_lo (
    .a(data_a_i[LSW-1:0]), .b(w_b_eff[LSW-1:0]), .cin(w_cin),
    .sum(w_sum_lo), .cout(w_c_lo)
  );

  logic [LSW-1:0] r1_sum_lo;
  logic           r1_c_lo;
  logic [HSW-1:0] r1_a_hi, r1_b_hi;
  logic [SWR-1:0] r1_p;
`ifdef ADD_SUBT_ABS_EN
  logic           r1_op;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1      <= 1'b0;
      r1_sum_lo <= '0;
      r1_c_lo   <= 1'b0;
      r1_a_hi   <= '0;
      r1_b_hi   <= '0;
      r1_p      <= '0;
`ifdef ADD_SUBT_ABS_EN
      r1_op     <= 1'b0;
`endif
    end else begin
      if (w_en1) r_v1 <= valid_i;
      if (w_acc) begin
        r1_sum_lo <= w_sum_lo;
        r1_c_lo   <= w_c_lo;
        r1_a_hi   <= data_a_i[SWR-1:LSW];
        r1_b_hi   <= w_b_eff[SWR-1:LSW];
        r1_p      <= data_a_i ^ w_b_eff;
`ifdef ADD_SUBT_ABS_EN
        r1_op     <= add_sub_op_i;
`endif
      end
    end
  end

  // ---------------- S2: high segment ----------------
  logic [HSW-1:0] w_sum_hi;
  logic           w_c_hi;
  logic [SWR-1:0] w_res2;

  add_seg #(.W(HSW)) u_seg_hi (
    .a(r1_a_hi), .b(r1_b_hi), .cin(r1_c_lo),
    .sum(w_sum_hi), .cout(w_c_hi)
  );
  assign w_res2 = {w_sum_hi, r1_sum_lo};

  logic [SWR-1:0] r2_res, r2_p;
  logic           r2_carry, r2_zero;
`ifdef ADD_SUBT_ABS_EN
  logic           r2_op;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2     <= 1'b0;
      r2_res   <= '0;
      r2_p     <= '0;
      r2_carry <= 1'b0;
      r2_zero  <= 1'b0;
`ifdef ADD_SUBT_ABS_EN
      r2_op    <= 1'b0;
`endif
    end else begin
      if (w_en2) r_v2 <= r_v1;
      if (w_en2 && r_v1) begin
        r2_res   <= w_res2;
        r2_p     <= r1_p;
        r2_carry <= w_c_hi;
        r2_zero  <= (w_res2 == '0);
`ifdef ADD_SUBT_ABS_EN
        r2_op    <= r1_op;
`endif
      end
    end
  end

`ifdef ADD_SUBT_ABS_EN
  // ---------------- S3: magnitude of a negative difference ----------------
  logic           w_neg;
  logic [SWR-1:0] w_res3;
  logic [SWR-1:0] r3_res, r3_p;
  logic           r3_carry, r3_zero, r3_flip;

  assign w_neg  = (r2_op == OP_SUB) & ~r2_carry;
  assign w_res3 = w_neg ? (~r2_res + {{(SWR-1){1'b0}}, 1'b1}) : r2_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v3     <= 1'b0;
      r3_res   <= '0;
      r3_p     <= '0;
      r3_carry <= 1'b0;
      r3_zero  <= 1'b0;
      r3_flip  <= 1'b0;
    end else begin
      if (w_en3) r_v3 <= r_v2;
      if (w_en3 && r_v2) begin
        r3_res   <= w_res3;
        r3_p     <= r2_p;
        r3_carry <= r2_carry;
        r3_zero  <= r2_zero;
        r3_flip  <= w_neg;
      end
    end
  end

  assign valid_o     = r_v3;
  assign result_o    = r3_res;
  assign carry_o     = r3_carry;
  assign p_o         = r3_p;
  assign zero_o      = r3_zero;
  assign sign_flip_o = r3_flip;
`else
  assign valid_o     = r_v2;
  assign result_o    = r2_res;
  assign carry_o     = r2_carry;
  assign p_o         = r2_p;
  assign zero_o      = r2_zero;
  assign sign_flip_o = 1'b0;
`endif
endmodule

// File: tb/tb_add_subt_pipe.sv
// Randomized + directed bench for add_subt_pipe against an arithmetic reference model.
module tb_add_subt_pipe;
  import add_subt_pkg::*;

  localparam int SWR = 26;
  localparam int LSW = 13;
`ifdef ADD_SUBT_ABS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_i, ready_o, add_sub_op_i;
  logic [SWR-1:0] data_a_i, data_b_i;
  logic           valid_o, ready_i;
  logic [SWR-1:0] result_o, p_o;
  logic           carry_o, zero_o, sign_flip_o;

  always #5 clk = ~clk;

  add_subt_pipe #(.SWR(SWR), .LSW(LSW)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .add_sub_op_i(add_sub_op_i), .data_a_i(data_a_i), .data_b_i(data_b_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .carry_o(carry_o), .p_o(p_o), .zero_o(zero_o), .sign_flip_o(sign_flip_o)
  );

  typedef struct {
    logic [SWR-1:0] res;
    logic           carry;
    logic [SWR-1:0] p;
    logic           zero;
    logic           flip;
  } exp_t;

  exp_t           q[$];
  int             n_cmp = 0, n_err = 0, n_out = 0;
  logic           last_acc = 1'b0, last_rdy = 1'b0;
  logic           prev_stall = 1'b0;
  logic [SWR-1:0] prev_res = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic modulo 2^SWR.
  function automatic exp_t model(input logic [SWR-1:0] a, input logic [SWR-1:0] b, input logic op);
    exp_t        e;
    logic [63:0] A, B, s;
    A = 64'(a);
    B = 64'(b);
    if (op == OP_SUB) s = A + ((64'd1 << SWR) - B);
    else              s = A + B;
    e.carry = s[SWR];
    e.res   = s[SWR-1:0];
    e.p     = (op == OP_SUB) ? (a ^ ~b) : (a ^ b);
    e.flip  = 1'b0;
`ifdef ADD_SUBT_ABS_EN
    if (op == OP_SUB && A < B) begin
      e.res  = SWR'(B - A);
      e.flip = 1'b1;
    end
`endif
    e.zero = (e.res == '0);
    return e;
  endfunction

  // One cycle: observe settled handshake, score transfers, advance to next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (prev_stall) begin
      chk("hold_valid", 64'(valid_o), 64'd1);
      chk("hold_res", 64'(result_o), 64'(prev_res));
    end
    last_rdy = ready_o;
    last_acc = valid_i & ready_o & !rst;
    if (valid_o && ready_i && !rst) begin
      n_out++;
      if (q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        chk("res",   64'(result_o),    64'(e.res));
        chk("carry", 64'(carry_o),     64'(e.carry));
        chk("p",     64'(p_o),         64'(e.p));
        chk("zero",  64'(zero_o),      64'(e.zero));
        chk("flip",  64'(sign_flip_o), 64'(e.flip));
      end
    end
    if (last_acc) q.push_back(model(data_a_i, data_b_i, add_sub_op_i));
    prev_stall = valid_o & !ready_i;
    prev_res   = result_o;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [SWR-1:0] a, input logic [SWR-1:0] b,
                          input logic op, input logic [SWR-1:0] x_res, input logic x_carry,
                          input logic x_zero, input logic x_flip, input logic [SWR-1:0] x_p);
    ready_i = 1'b1; valid_i = 1'b1;
    data_a_i = a; data_b_i = b; add_sub_op_i = op;
    tick();
    chk({tag, "_acc"}, 64'(last_acc), 64'd1);
    valid_i = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      chk({tag, "_early"}, 64'(valid_o), 64'd0);
      tick();
    end
    chk({tag, "_valid"}, 64'(valid_o),     64'd1);
    chk({tag, "_res"},   64'(result_o),    64'(x_res));
    chk({tag, "_carry"}, 64'(carry_o),     64'(x_carry));
    chk({tag, "_zero"},  64'(zero_o),      64'(x_zero));
    chk({tag, "_flip"},  64'(sign_flip_o), 64'(x_flip));
    chk({tag, "_p"},     64'(p_o),         64'(x_p));
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_sent, n_out0, cyc;
    logic seen_nr;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; add_sub_op_i = OP_ADD;
    data_a_i = '0; data_b_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_res",   64'(result_o), 64'd0);
    chk("rst_p",     64'(p_o), 64'd0);
    chk("rst_cz",    64'({carry_o, zero_o, sign_flip_o}), 64'd0);
    @(negedge clk);

    directed("add_segc", 26'h0001FFF, 26'h0000001, OP_ADD, 26'h0002000, 1'b0, 1'b0, 1'b0, 26'h0001FFE);
    directed("sub_eq",   26'h2AAAAAA, 26'h2AAAAAA, OP_SUB, 26'h0000000, 1'b1, 1'b1, 1'b0, 26'h3FFFFFF);
`ifdef ADD_SUBT_ABS_EN
    directed("sub_lt",   26'h0000005, 26'h0000008, OP_SUB, 26'h0000003, 1'b0, 1'b0, 1'b1, 26'h3FFFFF2);
`else
    directed("sub_lt",   26'h0000005, 26'h0000008, OP_SUB, 26'h3FFFFFD, 1'b0, 1'b0, 1'b0, 26'h3FFFFF2);
`endif
    directed("ovf",      26'h3FFFFFF, 26'h3FFFFFF, OP_ADD, 26'h3FFFFFE, 1'b1, 1'b0, 1'b0, 26'h0000000);

    // Backpressure: 5 beats, ready_i low in cycles 3..6.
    n_sent = 0; n_out0 = n_out; seen_nr = 1'b0;
    for (int c = 0; c < 40 && (n_sent < 5 || q.size() > 0); c++) begin
      ready_i      = !(c >= 3 && c <= 6);
      valid_i      = (n_sent < 5);
      data_a_i     = SWR'(n_sent * 32'h12345 + 7);
      data_b_i     = SWR'(n_sent * 32'h0F0F1);
      add_sub_op_i = n_sent[0];
      tick();
      if (!last_rdy) seen_nr = 1'b1;
      if (last_acc) n_sent++;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    chk("bp_rdy_drop", 64'(seen_nr), 64'd1);
    chk("bp_count", 64'(n_out - n_out0), 64'd5);
    chk("bp_sb_left", 64'(q.size()), 64'd0);

    // Reset mid-stream with two beats held inside the pipe.
    ready_i = 1'b0; n_sent = 0;
    for (int c = 0; c < 10 && n_sent < 2; c++) begin
      valid_i = 1'b1; data_a_i = SWR'($urandom); data_b_i = SWR'($urandom);
      add_sub_op_i = 1'($urandom);
      tick();
      if (last_acc) n_sent++;
    end
    valid_i = 1'b0;
    chk("mr_inflight", 64'(n_sent), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0; q.delete(); prev_stall = 1'b0; ready_i = 1'b1;
    #1;
    chk("mr_valid", 64'(valid_o), 64'd0);
    chk("mr_ready", 64'(ready_o), 64'd1);
    chk("mr_outs",  64'({result_o, carry_o, zero_o, sign_flip_o}), 64'd0);
    chk("mr_p",     64'(p_o), 64'd0);
    n_out0 = n_out;
    repeat (6) tick();
    chk("mr_no_stale", 64'(n_out - n_out0), 64'd0);

    // Random traffic with random backpressure.
    n_sent = 0; cyc = 0;
    while ((n_sent < 300 || valid_i || q.size() > 0) && cyc < 5000) begin
      if (last_acc) begin
        n_sent++;
        valid_i = 1'b0;
      end
      if (!valid_i && n_sent < 300 && ($urandom % 4 != 0)) begin
        valid_i      = 1'b1;
        add_sub_op_i = 1'($urandom);
        case ($urandom % 4)
          0: begin data_a_i = SWR'($urandom); data_b_i = SWR'($urandom); end
          1: begin data_a_i = SWR'($urandom); data_b_i = data_a_i; end
          2: begin data_a_i = SWR'($urandom % 64); data_b_i = SWR'($urandom % 64); end
          default: begin data_a_i = '1; data_b_i = SWR'($urandom) | SWR'(26'h3FFE000); end
        endcase
      end
      ready_i = ($urandom % 4 != 0);
      tick();
      cyc++;
    end
    chk("rand_done", 64'(n_sent >= 300), 64'd1);
    chk("rand_drain", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
